alu_seq_unit: RTL
=================

# alu_seq_unit

Parametrised, registered successor to the combinational ALU control decoder. Decodes ALUOp plus funct3/funct7 into a 4-bit control code and executes the operation on XLEN-bit operands. Shifts run iteratively and an optional multiplier runs as a multi-cycle path. Sits in the EX stage between the register-read stage and writeback, with valid/ready handshakes on both sides.

## Interface
- XLEN, 32: operand/result width; power of two, 8..64
- SHW, $clog2(XLEN): shift-amount width, derived; not overridden
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept
- alu_op  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7
- op_a  in  XLEN  operand A
- op_b  in  XLEN  operand B or immediate; shift amount = op_b[SHW-1:0]
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  XLEN  registered result
- zero  out  1  result == 0
- ctrl  out  4  decoded control code of the held operation
- illegal  out  1  held operation failed decode

## Operation
- Control codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, SLTU 1000, SLL 1001, SRL 1010, SRA 1011, MUL 1100, ILLEGAL 1111.
- alu_op 00 → ADD. alu_op 01 → SUB. funct fields ignored.
- alu_op 10, funct7 0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- alu_op 10, funct7 0100000: funct3 000 SUB, 101 SRA, others ILLEGAL.
- alu_op 11: decode by funct3 as R-type, with 000 → ADD regardless of funct7. For 101, funct7 0100000 → SRA, else SRL.
- Any other funct7 with alu_op 10 → ILLEGAL, except MUL under configuration.
- ILLEGAL: completes as a single-cycle op with result 0, zero 1, illegal 1.
- SLT is signed and SLTU unsigned; both give result {XLEN-1 zeros, flag}.
- ADD, SUB and MUL wrap modulo 2^XLEN, with no carry or overflow output.
- FSM states: IDLE, SHIFT, MUL, DONE.
  - IDLE: in_ready 1. On in_valid, capture operands, decode and latch ctrl.
    - Single-cycle ops and shifts with shamt 0: compute result → DONE.
    - Shifts with shamt > 0: load op_a, set counter = shamt → SHIFT.
    - MUL → MUL.
  - SHIFT: shift by 1 bit per cycle (SRA replicates the sign bit) and decrement the counter. On the cycle the counter reaches 0 → DONE.
  - MUL: shift-add, 1 bit of op_b per cycle, XLEN cycles → DONE.
  - DONE: out_valid 1. result, zero, ctrl and illegal are held stable. On out_ready → IDLE.
- in_ready is 0 in SHIFT, MUL and DONE. No accept is possible while a result is held.
- Inputs are sampled only at the accept edge; later changes are ignored.

## Timing
- Reset values: state IDLE, out_valid 0, result 0, zero 1, ctrl 0000, illegal 0. in_ready is 0 while reset is high.
- Accept in cycle c; out_valid rises at:
  - c+1 for single-cycle ops, ILLEGAL and shamt 0;
  - c+1+shamt for shifts;
  - c+1+XLEN for MUL.
- out_valid stays high until the cycle out_ready is sampled high, then drops next cycle. in_ready rises in that same next cycle.
- Peak throughput: 1 single-cycle op per 2 cycles.
- Reset mid-operation: the operation is aborted. Next cycle state is IDLE, out_valid 0 and no result is produced.
- shamt of XLEN-1 (the maximum) gives XLEN-1 shift cycles. No wrap beyond that, since shamt is masked to SHW bits.

## Configuration
- ALU_MUL_EN defined: alu_op 10, funct7 0000001, funct3 000 decodes to MUL (low XLEN bits of the product), using the MUL state and XLEN-cycle latency. Other funct3 values with funct7 0000001 are ILLEGAL.
- ALU_MUL_EN undefined: the MUL state and datapath are absent, and all funct7 0000001 encodings are ILLEGAL.

## Test plan
- XLEN=32, alu_op 10, f7 0100000, f3 000, A=5, B=7 → out_valid at c+1, result 0xFFFFFFFE, ctrl 0110, zero 0.
- alu_op 10, f7 0100000, f3 101, A=0x80000000, B=4 → out_valid at c+5, result 0xF8000000, ctrl 1011. in_ready is 0 for cycles c+1..c+5.
- alu_op 10, f3 010 vs 011, A=0xFFFFFFFF, B=1 → SLT result 1, SLTU result 0.
- alu_op 10, f7 1111111 → result 0, zero 1, illegal 1, ctrl 1111, out_valid at c+1.
- Hold out_ready 0 for 5 cycles after out_valid → result stable and in_ready 0 throughout. Assert reset during SHIFT → next cycle out_valid 0, state IDLE.
- ALU_MUL_EN: A=0xFFFF, B=0x10001 → out_valid at c+33, result 0xFFFFFFFF. Without the macro, the same encoding gives illegal 1.

Source files
------------

// File: rtl/alu_seq_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_seq_unit: registered ALU with control decode, iterative shifter and  |
// | optional shift-add multiplier (enabled by defining ALU_MUL_EN).          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_seq_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      ctrl,
  output logic            illegal
);

  localparam logic [3:0] c_AND  = 4'b0000;
  localparam logic [3:0] c_OR   = 4'b0001;
  localparam logic [3:0] c_ADD  = 4'b0010;
  localparam logic [3:0] c_XOR  = 4'b0011;
  localparam logic [3:0] c_SUB  = 4'b0110;
  localparam logic [3:0] c_SLT  = 4'b0111;
  localparam logic [3:0] c_SLTU = 4'b1000;
  localparam logic [3:0] c_SLL  = 4'b1001;
  localparam logic [3:0] c_SRL  = 4'b1010;
  localparam logic [3:0] c_SRA  = 4'b1011;
  localparam logic [3:0] c_ILL  = 4'b1111;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd3;
`ifdef ALU_MUL_EN
  localparam logic [3:0] c_MULC       = 4'b1100;
  localparam logic [1:0] c_MUL        = 2'd2;
  localparam logic [SHW:0] c_MUL_CYC  = (SHW+1)'(XLEN);
`endif

  localparam logic [6:0] c_F7_BASE = 7'b0000000;
  localparam logic [6:0] c_F7_ALT  = 7'b0100000;

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_result;
  logic [3:0]      r_ctrl;
  logic            r_illegal;
  logic [SHW:0]    r_cnt;
`ifdef ALU_MUL_EN
  logic [XLEN-1:0] r_ma;
  logic [XLEN-1:0] r_mb;
`endif

  logic [3:0]      w_ctrl;
  logic [3:0]      w_base;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_alu;
  logic            w_is_shift;

  assign w_shamt    = op_b[SHW-1:0];
  assign w_is_shift = (w_ctrl == c_SLL) || (w_ctrl == c_SRL) || (w_ctrl == c_SRA);

  // funct3 table shared by R-type (funct7 zero) and I-type
  always_comb begin
    w_base = c_ADD;
    case (funct3)
      3'b000:  w_base = c_ADD;
      3'b001:  w_base = c_SLL;
      3'b010:  w_base = c_SLT;
      3'b011:  w_base = c_SLTU;
      3'b100:  w_base = c_XOR;
      3'b101:  w_base = c_SRL;
      3'b110:  w_base = c_OR;
      default: w_base = c_AND;
    endcase
  end

  always_comb begin
    w_ctrl = c_ILL;
    case (alu_op)
      2'b00: w_ctrl = c_ADD;
      2'b01: w_ctrl = c_SUB;
      2'b10: begin
        if (funct7 == c_F7_BASE) begin
          w_ctrl = w_base;
        end else if (funct7 == c_F7_ALT) begin
          if (funct3 == 3'b000)      w_ctrl = c_SUB;
          else if (funct3 == 3'b101) w_ctrl = c_SRA;
          else                       w_ctrl = c_ILL;
`ifdef ALU_MUL_EN
        end else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin
          w_ctrl = c_MULC;
`endif
        end else begin
          w_ctrl = c_ILL;
        end
      end
      default: begin
        if (funct3 == 3'b101 && funct7 == c_F7_ALT) w_ctrl = c_SRA;
        else                                        w_ctrl = w_base;
      end
    endcase
  end

  // Shifts only reach this path with a zero shift amount, so they pass op_a
  always_comb begin
    w_alu = '0;
    case (w_ctrl)
      c_AND:  w_alu = op_a & op_b;
      c_OR:   w_alu = op_a | op_b;
      c_ADD:  w_alu = op_a + op_b;
      c_XOR:  w_alu = op_a ^ op_b;
      c_SUB:  w_alu = op_a - op_b;
      c_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      c_SLTU: w_alu = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      c_SLL, c_SRL, c_SRA: w_alu = op_a;
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= c_IDLE;
      r_result  <= '0;
      r_ctrl    <= 4'b0000;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
`ifdef ALU_MUL_EN
      r_ma      <= '0;
      r_mb      <= '0;
`endif
    end else begin
      case (r_state)
        c_IDLE: begin
          if (in_valid) begin
            r_ctrl    <= w_ctrl;
            r_illegal <= (w_ctrl == c_ILL);
            if (w_is_shift && w_shamt != '0) begin
              r_result <= op_a;
              r_cnt    <= {1'b0, w_shamt};
              r_state  <= c_SHIFT;
`ifdef ALU_MUL_EN
            end else if (w_ctrl == c_MULC) begin
              r_result <= '0;
              r_ma     <= op_a;
              r_mb     <= op_b;
              r_cnt    <= c_MUL_CYC;
              r_state  <= c_MUL;
`endif
            end else begin
              r_result <= w_alu;
              r_state  <= c_DONE;
            end
          end
        end
        c_SHIFT: begin
          case (r_ctrl)
            c_SLL:   r_result <= {r_result[XLEN-2:0], 1'b0};
            c_SRA:   r_result <= {r_result[XLEN-1], r_result[XLEN-1:1]};
            default: r_result <= {1'b0, r_result[XLEN-1:1]};
          endcase
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == (SHW+1)'(1)) r_state <= c_DONE;
        end
`ifdef ALU_MUL_EN
        c_MUL: begin
          if (r_mb[0]) r_result <= r_result + r_ma;
          r_ma  <= {r_ma[XLEN-2:0], 1'b0};
          r_mb  <= {1'b0, r_mb[XLEN-1:1]};
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == (SHW+1)'(1)) r_state <= c_DONE;
        end
`endif
        c_DONE: begin
          if (out_ready) r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == c_IDLE) && !reset;
  assign out_valid = (r_state == c_DONE);
  assign result    = r_result;
  assign zero      = (r_result == '0);
  assign ctrl      = r_ctrl;
  assign illegal   = r_illegal;

endmodule
`default_nettype wire
